// File: rtl/output_dma_arbiter.sv
// output_dma_arbiter
// Round-robin scheduler that shares one output DMA controller between several
// layer engines. Each requester owns a single descriptor slot; full slots are
// granted one at a time, the DMA is started, and the completion (and error)
// is routed back to the owning requester as a one-cycle pulse.

module output_dma_arbiter #(
   parameter int NUM_REQ    = 4,
   parameter int ADDR_WIDTH = 32,
   parameter int ID_W       = $clog2(NUM_REQ)
) (
   input  logic                          clk,
   input  logic                          rst_n,

   input  logic [NUM_REQ-1:0]            req_valid,
   output logic [NUM_REQ-1:0]            req_ready,
   input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_src_addr,
   input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_dst_addr,
   input  logic [NUM_REQ*16-1:0]         req_byte_count,
   output logic [NUM_REQ-1:0]            cpl_done,
   output logic [NUM_REQ-1:0]            cpl_error,

   output logic                          dma_start,
   output logic [ADDR_WIDTH-1:0]         dma_src_addr,
   output logic [ADDR_WIDTH-1:0]         dma_dst_addr,
   output logic [15:0]                   dma_byte_count,
   input  logic                          dma_done,
   input  logic                          dma_busy,
   input  logic                          dma_error,

   output logic                          active,
   output logic [ID_W-1:0]               active_id,
   output logic [15:0]                   xfer_count
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ISSUE = 2'd1,
      S_WAIT  = 2'd2,
      S_DRAIN = 2'd3
   } state_t;

   state_t r_state;
   state_t w_next_state;

   // Descriptor slots, one per requester
   logic [NUM_REQ-1:0]    r_slot_full;
   logic [ADDR_WIDTH-1:0] r_slot_src [NUM_REQ];
   logic [ADDR_WIDTH-1:0] r_slot_dst [NUM_REQ];
   logic [15:0]           r_slot_cnt [NUM_REQ];

   // Ownership and bookkeeping
   logic [ID_W-1:0]       r_last_grant;
   logic [ID_W-1:0]       r_active_id;
   logic [ADDR_WIDTH-1:0] r_dma_src;
   logic [ADDR_WIDTH-1:0] r_dma_dst;
   logic [15:0]           r_dma_cnt;
   logic [NUM_REQ-1:0]    r_cpl_done;
   logic [NUM_REQ-1:0]    r_cpl_error;
   logic [15:0]           r_xfer_count;

   // Arbitration and FSM decode
   logic                  w_found_hi;
   logic                  w_found_lo;
   logic [ID_W-1:0]       w_hi_id;
   logic [ID_W-1:0]       w_lo_id;
   logic                  w_any_full;
   logic [ID_W-1:0]       w_winner;
   logic                  w_grant;
   logic                  w_complete;
   logic [NUM_REQ-1:0]    w_active_onehot;

   // Round-robin pick: the first full slot above last_grant wins, otherwise
   // wrap around to the lowest-numbered full slot.
   always_comb begin
      w_found_hi = 1'b0;
      w_found_lo = 1'b0;
      w_hi_id    = '0;
      w_lo_id    = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (r_slot_full[i] && !w_found_lo) begin
            w_found_lo = 1'b1;
            w_lo_id    = ID_W'(i);
         end
         if (r_slot_full[i] && (ID_W'(i) > r_last_grant) && !w_found_hi) begin
            w_found_hi = 1'b1;
            w_hi_id    = ID_W'(i);
         end
      end
      w_any_full = w_found_lo;
      w_winner   = w_found_hi ? w_hi_id : w_lo_id;
   end

   // One-hot decode of the owning requester for the completion pulses
   always_comb begin
      w_active_onehot = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         w_active_onehot[i] = (r_active_id == ID_W'(i));
      end
   end

   // Slot occupancy: set on accept, cleared on the cycle the slot is granted
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_slot_full <= '0;
      end else begin
         for (int i = 0; i < NUM_REQ; i++) begin
            if (req_valid[i] && !r_slot_full[i]) begin
               r_slot_full[i] <= 1'b1;
            end else if (w_grant && (w_winner == ID_W'(i))) begin
               r_slot_full[i] <= 1'b0;
            end
         end
      end
   end

   // Descriptor payload capture; only meaningful while the slot is full
   always_ff @(posedge clk) begin
      for (int i = 0; i < NUM_REQ; i++) begin
         if (req_valid[i] && !r_slot_full[i]) begin
            r_slot_src[i] <= req_src_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
            r_slot_dst[i] <= req_dst_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
            r_slot_cnt[i] <= req_byte_count[i*16 +: 16];
         end
      end
   end

   // FSM state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   // FSM next-state: grant, issue, wait for done, drain a lingering done/busy
   always_comb begin
      w_next_state = r_state;
      w_grant      = 1'b0;
      w_complete   = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (w_any_full) begin
               w_grant      = 1'b1;
               w_next_state = S_ISSUE;
            end
         end
         S_ISSUE: begin
            w_next_state = S_WAIT;
         end
         S_WAIT: begin
            if (dma_done) begin
               w_complete   = 1'b1;
               w_next_state = S_DRAIN;
            end
         end
         S_DRAIN: begin
            if (!dma_done && !dma_busy) begin
               w_next_state = S_IDLE;
            end
         end
         default: begin
            w_next_state = S_IDLE;
         end
      endcase
   end

   // Grant bookkeeping: latch the winner's descriptor toward the DMA
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_last_grant <= ID_W'(NUM_REQ - 1);
         r_active_id  <= '0;
         r_dma_src    <= '0;
         r_dma_dst    <= '0;
         r_dma_cnt    <= '0;
      end else if (w_grant) begin
         r_last_grant <= w_winner;
         r_active_id  <= w_winner;
         r_dma_src    <= r_slot_src[w_winner];
         r_dma_dst    <= r_slot_dst[w_winner];
         r_dma_cnt    <= r_slot_cnt[w_winner];
      end
   end

   // Completion pulses and the transfer counter, one cycle after the DMA done
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cpl_done   <= '0;
         r_cpl_error  <= '0;
         r_xfer_count <= '0;
      end else begin
         r_cpl_done  <= w_complete ? w_active_onehot : '0;
         r_cpl_error <= (w_complete && dma_error) ? w_active_onehot : '0;
         if (w_complete) begin
            r_xfer_count <= r_xfer_count + 16'd1;
         end
      end
   end

   assign req_ready      = ~r_slot_full;
   assign cpl_done       = r_cpl_done;
   assign cpl_error      = r_cpl_error;
   assign dma_start      = (r_state == S_ISSUE);
   assign dma_src_addr   = r_dma_src;
   assign dma_dst_addr   = r_dma_dst;
   assign dma_byte_count = r_dma_cnt;
   assign active         = (r_state != S_IDLE);
   assign active_id      = r_active_id;
   assign xfer_count     = r_xfer_count;

endmodule

// File: doc/output_dma_arbiter.md
# output_dma_arbiter

Round-robin scheduler that shares one `output_dma_controller` between up to `NUM_REQ` layer engines. Each engine posts a single write-back descriptor (BRAM source, external destination, byte count). The block queues one descriptor per requester and issues them to the DMA one at a time. It pulses `start`, waits for the DMA's completion, and then returns a per-requester done/error pulse. It sits between the layer sequencers and the DMA's control port; the DMA's BRAM and AXI ports are untouched.

## Interface
- `NUM_REQ`, 4: number of requesters, 2..8.
- `ADDR_WIDTH`, 32: address width, matches the DMA.
- `ID_W`, `$clog2(NUM_REQ)`: requester index width.

- `clk`  in  1  clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `req_valid`  in  NUM_REQ  descriptor valid, one bit per requester.
- `req_ready`  out  NUM_REQ  descriptor slot empty, `= ~slot_full`.
- `req_src_addr`  in  NUM_REQ*ADDR_WIDTH  flattened; requester i occupies bits `[i*ADDR_WIDTH +: ADDR_WIDTH]`.
- `req_dst_addr`  in  NUM_REQ*ADDR_WIDTH  flattened, same packing.
- `req_byte_count`  in  NUM_REQ*16  flattened, 16 bits per requester.
- `cpl_done`  out  NUM_REQ  one-cycle completion pulse to the granted requester.
- `cpl_error`  out  NUM_REQ  one-cycle pulse, coincident with `cpl_done`, when the DMA reported an error.
- `dma_start`  out  1  start pulse to the DMA.
- `dma_src_addr`  out  ADDR_WIDTH  source address driven to the DMA.
- `dma_dst_addr`  out  ADDR_WIDTH  destination address driven to the DMA.
- `dma_byte_count`  out  16  byte count driven to the DMA.
- `dma_done`  in  1  DMA done.
- `dma_busy`  in  1  DMA busy.
- `dma_error`  in  1  DMA error.
- `active`  out  1  a transfer is owned, i.e. state ≠ IDLE.
- `active_id`  out  ID_W  owning requester.
- `xfer_count`  out  16  completed transfers, wraps at 0xFFFF→0.

## Operation
**Descriptor slots**
- One slot per requester.
- Accept when `req_valid[i] & req_ready[i]`: capture src/dst/count and set `slot_full[i]`.
- `slot_full[i]` clears on the cycle requester i is granted, so the requester may queue its next descriptor while its current one runs.

**Arbitration**
- Round-robin over full slots, searching upward from `last_grant+1` modulo NUM_REQ.
- `last_grant` resets to NUM_REQ-1, so requester 0 wins first.

**FSM**
- IDLE:
  - If any slot is full, select winner w.
  - Register w's descriptor into `dma_*_addr` and `dma_byte_count`.
  - Set `active_id<=w`, `last_grant<=w`, clear `slot_full[w]`, go ISSUE.
- ISSUE:
  - `dma_start`=1 for this cycle only; go WAIT.
- WAIT:
  - On `dma_done`=1: pulse `cpl_done[active_id]`.
  - In the same cycle, pulse `cpl_error[active_id]` if `dma_error`=1 at that cycle; `dma_error` is sampled only together with `dma_done`.
  - Increment `xfer_count`, go DRAIN.
- DRAIN:
  - Wait until `dma_done`=0 and `dma_busy`=0, then go IDLE.
  - This absorbs the DMA's two-cycle done on zero-length transfers, so only one `cpl_done` is issued per descriptor.

**General rules**
- `dma_start` is never high outside ISSUE.
- `dma_*` address and count outputs hold from ISSUE until the next grant.
- Descriptor acceptance for other requesters continues in every state.

## Timing
**Reset values (`rst_n`=0, asynchronous)**
- State IDLE.
- `req_ready` all-ones.
- `cpl_done`, `cpl_error`, `dma_start` all 0.
- `dma_src_addr`, `dma_dst_addr`, `dma_byte_count` all 0.
- `active`=0, `active_id`=0, `xfer_count`=0.
- All slots empty.

**Latency**
- Accept at edge t → IDLE sees the full slot at t+1 → `dma_start` high during cycle t+2.
- `dma_done` seen in cycle c → `cpl_done` high in cycle c+1.
- Earliest next `dma_start` is c+3 (DRAIN, then IDLE, then ISSUE).

**Boundary conditions**
- Simultaneous accept and grant on different requesters is legal.
- On the granted requester, the slot clears that cycle; a new `req_valid` is accepted from the next cycle, when `req_ready[w]` has returned to 1.
- `dma_done` arriving in ISSUE (illegal DMA behaviour) is ignored; only WAIT samples it.
- Reset mid-transfer:
  - All slots are dropped and no `cpl_*` pulse is issued.
  - The DMA must be reset in the same cycle; this is the integrator's responsibility.

## Test plan
- Single request: r0 posts {src 0x000, dst 0x1000_0000, count 512} → `dma_start` 2 cycles after accept with those values; DMA model done after 770 cycles → `cpl_done[0]` one pulse; `xfer_count`=1.
- r1 and r2 post in the same cycle, reset pointer → grants go r1 then r2; `dma_start` pulses separated by ≥3 cycles after the first done; `cpl_done[1]` precedes `cpl_done[2]`.
- All four requesters continuously re-request, 12 transfers → grant order 0,1,2,3,0,1,2,3,…; each requester gets exactly 3 grants.
- DMA model asserts `dma_error` with done on r3's transfer (count 40) → `cpl_done[3]` and `cpl_error[3]` coincide; the next transfer proceeds normally.
- Zero-length count=0 with the DMA model raising done for 2 cycles → exactly one `cpl_done`; FSM returns to IDLE only after done drops; `xfer_count` +1.
- `rst_n` low in WAIT with r0 active and r1 queued → outputs at reset values immediately; after release, no `cpl_*` pulses and no `dma_start` until a new request arrives.
